// File: rtl/mmu_pkg.sv
// Shared types and defaults for the N x N output-stationary systolic multiplier.
package mmu_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  localparam int unsigned DefN  = 2;
  localparam int unsigned DefDw = 8;
  localparam int unsigned DefAw = 16;

  // Cycles needed for the last beat to reach PE(N-1,N-1) and be accumulated.
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/mmu_pe.sv
// One processing element: pass-through operand registers and a wrapping MAC.
module mmu_pe
  import mmu_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic          clear,
  input  logic          signed_mode,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [DW-1:0] a_q, b_q;
  logic [AW-1:0] acc_q;

  logic signed [AW-1:0] a_s, b_s, prod_s;
  logic [AW-1:0]        a_u, b_u, prod_u, prod;

  // Operands are widened to AW before the multiply; AW >= 2*DW keeps the product exact.
  assign a_s    = AW'($signed(a_in));
  assign b_s    = AW'($signed(b_in));
  assign prod_s = a_s * b_s;
  assign a_u    = AW'(a_in);
  assign b_u    = AW'(b_in);
  assign prod_u = a_u * b_u;
  assign prod   = signed_mode ? prod_s : prod_u;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clear) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (shift) begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_q + prod;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/mmu_array.sv
// N x N output-stationary systolic array computing C = A x B over a streamed inner dimension.
module mmu_array
  import mmu_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic              signed_mode,
  input  logic [N*DW-1:0]   a_in,
  input  logic [N*DW-1:0]   b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*AW-1:0] c_out
);

  localparam int unsigned FlushLen = flush_len(N);
  localparam int unsigned CntW     = $clog2(FlushLen + 1);

  state_e          state_q;
  logic            mode_q;
  logic [CntW-1:0] cnt_q;
  logic            in_ready_q, out_valid_q;

  logic accept, shift, clear, mode_eff;

  assign accept = in_valid & in_ready_q;
  assign shift  = (state_q != StDone);
  assign clear  = (state_q == StDone) & out_ready;
  // The first beat is accumulated at PE(0,0) on the same edge that latches the mode.
  assign mode_eff = (state_q == StIdle) ? signed_mode : mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            mode_q <= signed_mode;
            cnt_q  <= '0;
            if (in_last) begin
              state_q    <= StFlush;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (accept && in_last) begin
            state_q    <= StFlush;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
          end
        end
        StFlush: begin
          if (cnt_q == CntW'(FlushLen - 1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  logic [DW-1:0] a_sk   [N];
  logic [DW-1:0] b_sk   [N];
  logic [DW-1:0] a_pass [N][N];
  logic [DW-1:0] b_pass [N][N];

  // Lane i of A and lane i of B both need i cycles of delay.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_lane, b_lane;
    assign a_lane = accept ? a_in[i*DW +: DW] : '0;
    assign b_lane = accept ? b_in[i*DW +: DW] : '0;

    if (i == 0) begin : g_direct
      assign a_sk[i] = a_lane;
      assign b_sk[i] = b_lane;
    end else begin : g_chain
      logic [DW-1:0] sa_q [i];
      logic [DW-1:0] sb_q [i];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < i; s++) begin
            sa_q[s] <= '0;
            sb_q[s] <= '0;
          end
        end else if (clear) begin
          for (int s = 0; s < i; s++) begin
            sa_q[s] <= '0;
            sb_q[s] <= '0;
          end
        end else if (shift) begin
          sa_q[0] <= a_lane;
          sb_q[0] <= b_lane;
          for (int s = 1; s < i; s++) begin
            sa_q[s] <= sa_q[s-1];
            sb_q[s] <= sb_q[s-1];
          end
        end
      end

      assign a_sk[i] = sa_q[i-1];
      assign b_sk[i] = sb_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_src, b_src;

      if (j == 0) begin : g_a_edge
        assign a_src = a_sk[i];
      end else begin : g_a_inner
        assign a_src = a_pass[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_src = b_sk[j];
      end else begin : g_b_inner
        assign b_src = b_pass[i-1][j];
      end

      mmu_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk        (clk),
        .rst        (rst),
        .shift      (shift),
        .clear      (clear),
        .signed_mode(mode_eff),
        .a_in       (a_src),
        .b_in       (b_src),
        .a_out      (a_pass[i][j]),
        .b_out      (b_pass[i][j]),
        .acc        (c_out[(i*N+j)*AW +: AW])
      );
    end
  end

endmodule

// File: tb/tb_mmu_array.sv
// Self-checking bench for mmu_array: directed jobs plus randomized jobs against a matrix model.
module tb_mmu_array;

  localparam int unsigned N    = 2;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 16;
  localparam int unsigned CW   = N * N * AW;
  localparam int          KMAX = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_last, signed_mode;
  logic [N*DW-1:0] a_in, b_in;
  logic            out_valid, out_ready;
  logic [CW-1:0]   c_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] am [N][KMAX];
  logic [DW-1:0] bm [KMAX][N];

  mmu_array #(
    .N (N),
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .signed_mode(signed_mode),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c_out      (c_out)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Plain matrix product over integers, wrapped to AW bits.
  function automatic logic [AW-1:0] model_c(input int i, input int j, input int k_len,
                                            input bit sm);
    longint sum = 0;
    longint va, vb;
    for (int k = 0; k < k_len; k++) begin
      va = longint'(am[i][k]);
      vb = longint'(bm[k][j]);
      if (sm && am[i][k][DW-1]) va -= (longint'(1) << DW);
      if (sm && bm[k][j][DW-1]) vb -= (longint'(1) << DW);
      sum += va * vb;
    end
    return sum[AW-1:0];
  endfunction

  function automatic logic [CW-1:0] model_vec(input int k_len, input bit sm);
    logic [CW-1:0] v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        v[(i*N+j)*AW +: AW] = model_c(i, j, k_len, sm);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pack_a(input int k);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = am[i][k];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(input int k);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = bm[k][j];
    return v;
  endfunction

  task automatic set_job1();
    am[0][0] = 8'd1; am[0][1] = 8'd2; am[1][0] = 8'd3; am[1][1] = 8'd4;
    bm[0][0] = 8'd5; bm[0][1] = 8'd6; bm[1][0] = 8'd7; bm[1][1] = 8'd8;
  endtask

  // Streams one job; starts and ends on a falling edge.
  task automatic run_job(input int k_len, input bit sm, input bit toggle, input int gap,
                         input int bp, input bit has_const, input logic [CW-1:0] exp_const,
                         input bit rst_in_flush);
    logic [CW-1:0] exp;
    int t, lat;
    exp = model_vec(k_len, sm);
    for (int k = 0; k < k_len; k++) begin
      if (k > 0) begin
        repeat (gap) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom);
          a_in     = (N*DW)'($urandom);
          b_in     = (N*DW)'($urandom);
          @(negedge clk);
        end
      end
      in_valid    = 1'b1;
      a_in        = pack_a(k);
      b_in        = pack_b(k);
      in_last     = (k == k_len - 1);
      signed_mode = (k > 0 && toggle) ? ~sm : sm;
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      check_bit("in_ready_for_beat", in_ready, 1'b1);
      @(negedge clk);
    end
    in_valid    = 1'b0;
    in_last     = 1'b0;
    signed_mode = ~sm;
    a_in        = (N*DW)'($urandom);
    b_in        = (N*DW)'($urandom);

    if (rst_in_flush) begin
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_vec("rst_c_out", c_out, '0);
      check_bit("rst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1 check_bit("rst_release_in_ready", in_ready, 1'b0);
      @(negedge clk);
      check_bit("post_release_in_ready", in_ready, 1'b1);
      return;
    end

    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_vec("latency", CW'(lat), CW'(2 * N - 1));
    check_vec("c_out_model", c_out, exp);
    if (has_const) check_vec("c_out_const", c_out, exp_const);

    for (int c = 0; c < bp; c++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_last   = 1'b1;
      a_in      = (N*DW)'($urandom);
      b_in      = (N*DW)'($urandom);
      @(negedge clk);
      check_bit("bp_out_valid", out_valid, 1'b1);
      check_bit("bp_in_ready", in_ready, 1'b0);
      check_vec("bp_c_out_stable", c_out, exp);
    end

    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bit("hs_out_valid", out_valid, 1'b0);
    check_vec("hs_acc_cleared", c_out, '0);
    check_bit("hs_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    int k_len, gap, bp;
    bit sm, tg;
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    signed_mode = 1'b0;
    a_in        = '0;
    b_in        = '0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset_in_ready", in_ready, 1'b0);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_vec("reset_c_out", c_out, '0);
    rst = 1'b1;

    // Unsigned 2x2, back to back and with a 3-cycle bubble.
    set_job1();
    run_job(2, 1'b0, 1'b0, 0, 0, 1'b1, 64'h0032_002B_0016_0013, 1'b0);
    run_job(2, 1'b0, 1'b0, 3, 0, 1'b1, 64'h0032_002B_0016_0013, 1'b0);

    // K = 1
    am[0][0] = 8'd2; am[1][0] = 8'd3; bm[0][0] = 8'd4; bm[0][1] = 8'd5;
    run_job(1, 1'b0, 1'b0, 0, 0, 1'b1, 64'h000F_000C_000A_0008, 1'b0);

    // Signed, then signed with mode toggled on the second beat.
    am[0][0] = 8'hFF; am[0][1] = 8'd2; am[1][0] = 8'd3; am[1][1] = 8'hFC;
    bm[0][0] = 8'd5;  bm[0][1] = 8'd6; bm[1][0] = 8'd7; bm[1][1] = 8'd8;
    run_job(2, 1'b1, 1'b0, 0, 0, 1'b1, 64'hFFF2_FFF3_000A_0009, 1'b0);
    run_job(2, 1'b1, 1'b1, 1, 0, 1'b1, 64'hFFF2_FFF3_000A_0009, 1'b0);

    // Wrap with 5 cycles of backpressure, then a clean job afterwards.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) begin
        am[i][k] = 8'hFF;
        bm[k][i] = 8'hFF;
      end
    run_job(2, 1'b0, 1'b0, 0, 5, 1'b1, 64'hFC02_FC02_FC02_FC02, 1'b0);
    set_job1();
    run_job(2, 1'b0, 1'b0, 0, 0, 1'b1, 64'h0032_002B_0016_0013, 1'b0);

    // Reset during FLUSH, then the first job again.
    run_job(2, 1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b1);
    run_job(2, 1'b0, 1'b0, 0, 0, 1'b1, 64'h0032_002B_0016_0013, 1'b0);

    for (int r = 0; r < 25; r++) begin
      k_len = int'($urandom_range(1, KMAX));
      sm    = 1'($urandom);
      tg    = 1'($urandom);
      gap   = int'($urandom_range(0, 2));
      bp    = int'($urandom_range(0, 3));
      for (int i = 0; i < N; i++)
        for (int k = 0; k < KMAX; k++) begin
          am[i][k] = DW'($urandom);
          bm[k][i] = DW'($urandom);
        end
      run_job(k_len, sm, tg, gap, bp, 1'b0, '0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
